// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the 128x32 instruction memory.
// Takes a length byte N (0 means DEPTH_WORDS) followed by 4*N instruction
// bytes, MSB first, packs them into 32-bit words and writes them to
// consecutive word addresses. The processor is held in reset until the
// load completes successfully.
//
// Handshake: a byte moves only on a rising edge where in_valid && in_ready.
// in_ready is decoded from state alone, so it never depends on in_valid,
// and the source may raise or drop in_valid at any time without loss.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 LEN, 2 BYTES, 3 WRITE,
// 4 DONE, 5 ERR.
module imem_loader #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam int WIDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_BYTES = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_count;
    logic [WIDX_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_asm;

    logic              w_hs;
    logic              w_start_ok;
    logic              w_len_zero;
    logic              w_len_bad;
    logic [CNT_W-1:0]  w_idx_plus1;
    logic              w_last_word;

    // A byte is consumed only when both sides agree on this edge.
    assign w_hs        = in_valid && in_ready;
    // start is honoured only while no load is in progress.
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    assign w_len_zero  = (in_byte == 8'd0);
    assign w_len_bad   = (int'(in_byte) > DEPTH_WORDS);
    // Widen before adding so the final word of a full-depth load compares
    // against a count of DEPTH_WORDS without the index ever wrapping.
    assign w_idx_plus1 = CNT_W'(r_word_idx) + CNT_W'(1);
    assign w_last_word = (w_idx_plus1 == r_count);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_hs) begin
                    if (w_len_bad) w_next = S_ERR;
                    else           w_next = S_BYTES;
                end
            end
            S_BYTES: begin
                if (w_hs && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_last_word) w_next = S_DONE;
                else             w_next = S_BYTES;
            end
            S_DONE: begin
                if (w_start_ok) w_next = S_LEN;
            end
            S_ERR: begin
                if (w_start_ok) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the state register only.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            S_LEN:   in_ready = 1'b1;
            S_BYTES: in_ready = 1'b1;
            S_WRITE: wr_en    = 1'b1;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR:   err      = 1'b1;
            default: ;
        endcase
    end

    // Length latch, word/byte indices and the big-endian assembly register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_hs) begin
                        r_count    <= w_len_zero ? DEPTH_CNT : in_byte;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_BYTES: begin
                    if (w_hs) begin
                        r_asm      <= {r_asm[23:0], in_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    // Hold the index on the final word so it cannot wrap.
                    if (!w_last_word) r_word_idx <= r_word_idx + WIDX_W'(1);
                    r_byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr   = {r_word_idx, 2'b00};
    assign wr_data   = r_asm;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle table for the basic load, then directed
// sequences for gaps, full depth, bad length, reset mid-word and reload.
module tb_imem_loader;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_BYTES = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    logic [40:0] exp_q[$];

    typedef struct {
        logic        start;
        logic        vld;
        logic [7:0]  b;
        logic        exp_rdy;
        logic        exp_wr;
        logic [8:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_hold;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    imem_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [40:0] e;
        if (wr_en === 1'b1) begin
            n_writes++;
            check("ready_during_write", {63'd0, in_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("write_word", {23'd0, wr_addr, wr_data}, {23'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one byte and return #1 after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        logic acc;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom_range(0, 255));
                step();
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 20; t++) begin
            acc = in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no accept for byte %h expected accept within 20 cycles", b);
    endtask

    function automatic logic [4:0] ctl();
        return {in_ready, wr_en, cpu_hold, done, err};
    endfunction

    function automatic logic [48:0] all_out();
        return {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, dbg_state};
    endfunction

    initial begin
        logic [48:0] rst_vals;
        logic [31:0] w;
        logic [4:0]  got;
        logic [4:0]  req;
        int          base;

        rst_vals = {1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 1'b0, ST_IDLE};

        // Table rows: inputs before an edge, outputs expected just after it.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 9'h000, 32'h20087FFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 9'h004, 32'h20090000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0};

        // Reset
        #2 reset_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", {15'd0, all_out()}, {15'd0, rst_vals});
        reset_n = 1'b1;
        step();
        check("idle_outputs", {15'd0, all_out()}, {15'd0, rst_vals});

        // Basic load, cycle by cycle
        exp_q.push_back({9'h000, 32'h20087FFF});
        exp_q.push_back({9'h004, 32'h20090000});
        for (int i = 0; i < 13; i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].vld;
            in_byte  = vecs[i].b;
            step();
            got = ctl();
            req = {vecs[i].exp_rdy, vecs[i].exp_wr, vecs[i].exp_hold,
                   vecs[i].exp_done, vecs[i].exp_err};
            check($sformatf("basic_ctl_%0d", i), {59'd0, got}, {59'd0, req});
            if (vecs[i].exp_wr)
                check($sformatf("basic_word_%0d", i), {23'd0, wr_addr, wr_data},
                      {23'd0, vecs[i].exp_addr, vecs[i].exp_data});
        end
        start = 1'b0;
        in_valid = 1'b0;

        // Same stream with random valid gaps
        do_start();
        exp_q.push_back({9'h000, 32'h20087FFF});
        exp_q.push_back({9'h004, 32'h20090000});
        base = n_writes;
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h09, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        step();
        check("gaps_done", {59'd0, ctl()}, {59'd0, 5'b00010});
        step();
        check("gaps_writes", n_writes - base, 2);

        // Full depth: N=0 means 128 words
        do_start();
        base = n_writes;
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 128; k++) begin
            w = {8'(k), ~8'(k), 8'h5A, 8'(k) ^ 8'h3C};
            exp_q.push_back({9'(k * 4), w});
            send_byte(w[31:24], 1'b0);
            send_byte(w[23:16], 1'b0);
            send_byte(w[15:8], 1'b0);
            send_byte(w[7:0], 1'b0);
        end
        step();
        check("full_done_next_cycle", {59'd0, ctl()}, {59'd0, 5'b00010});
        repeat (4) step();
        check("full_write_count", n_writes - base, 128);

        // Bad length 0xC8
        do_start();
        base = n_writes;
        send_byte(8'hC8, 1'b0);
        check("bad_err_ctl", {59'd0, ctl()}, {59'd0, 5'b00101});
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_byte = 8'(i * 17);
            step();
        end
        in_valid = 1'b0;
        check("bad_state", {61'd0, dbg_state}, {61'd0, ST_ERR});
        check("bad_no_writes", n_writes - base, 0);
        do_start();
        check("bad_restart_ctl", {59'd0, ctl()}, {59'd0, 5'b10100});
        exp_q.push_back({9'h000, 32'h11223344});
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        step();
        check("bad_reload_done", {59'd0, ctl()}, {59'd0, 5'b00010});

        // Reset in the middle of a word
        do_start();
        base = n_writes;
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        reset_n = 1'b0;
        step();
        check("midreset_outputs", {15'd0, all_out()}, {15'd0, rst_vals});
        reset_n = 1'b1;
        step();
        step();
        check("midreset_idle", {15'd0, all_out()}, {15'd0, rst_vals});
        check("midreset_no_write", n_writes - base, 0);
        exp_q.push_back({9'h000, 32'hAABBCCDD});
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        step();
        check("midreset_reload_done", {59'd0, ctl()}, {59'd0, 5'b00010});

        // start mid-load is ignored, start after done reloads
        do_start();
        exp_q.push_back({9'h000, 32'hCAFEBABE});
        exp_q.push_back({9'h004, 32'h01234567});
        send_byte(8'h02, 1'b0);
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        do_start();
        check("ignored_start_bytes", {61'd0, dbg_state}, {61'd0, ST_BYTES});
        send_byte(8'hBA, 1'b0);
        send_byte(8'hBE, 1'b0);
        do_start();
        check("ignored_start_write", {61'd0, dbg_state}, {61'd0, ST_BYTES});
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h67, 1'b0);
        step();
        check("ignored_done", {59'd0, ctl()}, {59'd0, 5'b00010});
        do_start();
        check("reload_ctl", {59'd0, ctl()}, {59'd0, 5'b10100});
        check("reload_state", {61'd0, dbg_state}, {61'd0, ST_LEN});
        exp_q.push_back({9'h000, 32'hDEADBEEF});
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        step();
        check("reload_done", {59'd0, ctl()}, {59'd0, 5'b00010});
        repeat (3) step();

        check("expected_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
